// File: rtl/writeback_stage.sv
// Writeback stage: retires ALU results directly and completes loads by waiting
// for a memory response, extracting the addressed byte/halfword/word.
module writeback_stage #(
    parameter int unsigned MEM_TIMEOUT = 255
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        EX_VALID,
    output logic        EX_READY,
    input  logic [4:0]  EX_RD,
    input  logic [2:0]  EX_FUNCT3,
    input  logic        EX_IS_LOAD,
    input  logic        EX_WEN,
    input  logic [31:0] EX_RESULT,
    input  logic        MEM_RVALID,
    input  logic [31:0] MEM_RDATA,
    output logic [4:0]  A3,
    output logic [31:0] WB,
    output logic        WE,
    output logic        BUSY,
    output logic [4:0]  BUSY_RD,
    output logic        LOAD_ERR,
    output logic [63:0] INSTRET,
    output logic        dbg_state
);

    // Counter runs 0..MEM_TIMEOUT-1; the cycle it holds the last value without
    // a response is the timeout cycle.
    localparam int unsigned TW = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT);
    localparam logic [TW-1:0] TO_LAST = TW'(MEM_TIMEOUT - 1);

    typedef enum logic {
        IDLE     = 1'b0,
        WAIT_MEM = 1'b1
    } state_t;

    state_t        state, state_nx;
    logic [TW-1:0] cnt_q, cnt_nx;
    logic [4:0]    rd_q;
    logic [2:0]    f3_q;
    logic [1:0]    off_q;
    logic [4:0]    a3_q, a3_nx;
    logic [31:0]   wb_q, wb_nx;
    logic          we_q, we_nx;
    logic          err_q, err_nx;
    logic [63:0]   instret_q;
    logic          retire;
    logic          take_load;
    logic [31:0]   ld_data;
    logic          ld_bad;
    logic [7:0]    ld_byte;
    logic [15:0]   ld_half;

    // EX handshake: an instruction transfers on any cycle with EX_VALID && EX_READY;
    // EX_READY depends only on state, never on EX_VALID.
    assign EX_READY  = (state == IDLE);
    assign BUSY      = (state == WAIT_MEM);
    assign BUSY_RD   = BUSY ? rd_q : 5'd0;
    assign A3        = a3_q;
    assign WB        = wb_q;
    assign WE        = we_q;
    assign LOAD_ERR  = err_q;
    assign INSTRET   = instret_q;
    assign dbg_state = state;

    assign ld_byte = 8'(MEM_RDATA >> {off_q, 3'b000});
    assign ld_half = 16'(MEM_RDATA >> {off_q[1], 4'b0000});

    always_comb begin
        ld_data = 32'd0;
        ld_bad  = 1'b0;
        case (f3_q)
            3'b000:  ld_data = {{24{ld_byte[7]}}, ld_byte};
            3'b001: begin
                ld_bad  = off_q[0];
                ld_data = {{16{ld_half[15]}}, ld_half};
            end
            3'b010: begin
                ld_bad  = (off_q != 2'd0);
                ld_data = MEM_RDATA;
            end
            3'b100:  ld_data = {24'd0, ld_byte};
            3'b101: begin
                ld_bad  = off_q[0];
                ld_data = {16'd0, ld_half};
            end
            default: ld_bad = 1'b1;
        endcase
    end

    always_comb begin
        state_nx  = state;
        cnt_nx    = cnt_q;
        a3_nx     = a3_q;
        wb_nx     = wb_q;
        we_nx     = 1'b0;
        err_nx    = 1'b0;
        retire    = 1'b0;
        take_load = 1'b0;
        case (state)
            IDLE: begin
                if (EX_VALID) begin
                    if (EX_IS_LOAD) begin
                        take_load = 1'b1;
                        cnt_nx    = '0;
                        state_nx  = WAIT_MEM;
                    end else begin
                        we_nx  = EX_WEN && (EX_RD != 5'd0);
                        a3_nx  = EX_RD;
                        wb_nx  = EX_RESULT;
                        retire = 1'b1;
                    end
                end
            end
            WAIT_MEM: begin
                // A response on the timeout cycle takes priority over the timeout.
                if (MEM_RVALID) begin
                    state_nx = IDLE;
                    if (ld_bad) begin
                        err_nx = 1'b1;
                    end else begin
                        we_nx  = (rd_q != 5'd0);
                        a3_nx  = rd_q;
                        wb_nx  = ld_data;
                        retire = 1'b1;
                    end
                end else if (cnt_q == TO_LAST) begin
                    err_nx   = 1'b1;
                    state_nx = IDLE;
                end else begin
                    cnt_nx = cnt_q + TW'(1);
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state     <= IDLE;
            cnt_q     <= '0;
            rd_q      <= 5'd0;
            f3_q      <= 3'd0;
            off_q     <= 2'd0;
            a3_q      <= 5'd0;
            wb_q      <= 32'd0;
            we_q      <= 1'b0;
            err_q     <= 1'b0;
            instret_q <= 64'd0;
        end else begin
            state <= state_nx;
            cnt_q <= cnt_nx;
            a3_q  <= a3_nx;
            wb_q  <= wb_nx;
            we_q  <= we_nx;
            err_q <= err_nx;
            if (retire) instret_q <= instret_q + 64'd1;
            if (take_load) begin
                rd_q  <= EX_RD;
                f3_q  <= EX_FUNCT3;
                off_q <= EX_RESULT[1:0];
            end
        end
    end

endmodule

// File: doc/writeback_stage.md
WRITEBACK_STAGE -- requirements
Module: writeback_stage

Interface
REQ-001 The module SHALL have parameter MEM_TIMEOUT, default 255, giving the maximum WAIT_MEM cycles without a memory response.
REQ-002 The module SHALL have port CLK  input  1  clock; all state updates on its rising edge.
REQ-003 The module SHALL have port RST  input  1  reset, asynchronous, active-low.
REQ-004 The module SHALL have port EX_VALID  input  1  execute stage presents an instruction.
REQ-005 The module SHALL have port EX_READY  output  1  block accepts an instruction this cycle.
REQ-006 The module SHALL have port EX_RD  input  5  destination register index.
REQ-007 The module SHALL have port EX_FUNCT3  input  3  load width/sign code.
REQ-008 The module SHALL have port EX_IS_LOAD  input  1  instruction is a load.
REQ-009 The module SHALL have port EX_WEN  input  1  instruction writes rd.
REQ-010 The module SHALL have port EX_RESULT  input  32  ALU result, or load byte address when EX_IS_LOAD=1.
REQ-011 The module SHALL have port MEM_RVALID  input  1  load data valid.
REQ-012 The module SHALL have port MEM_RDATA  input  32  aligned 32-bit word containing the load target.
REQ-013 The module SHALL have port A3  output  5  register file write index.
REQ-014 The module SHALL have port WB  output  32  register file write data.
REQ-015 The module SHALL have port WE  output  1  register file write enable, one-cycle pulse.
REQ-016 The module SHALL have port BUSY  output  1  a load is outstanding.
REQ-017 The module SHALL have port BUSY_RD  output  5  rd of the outstanding load, 0 when BUSY=0.
REQ-018 The module SHALL have port LOAD_ERR  output  1  one-cycle pulse on a failed load.
REQ-019 The module SHALL have port INSTRET  output  64  count of retired instructions.

Function
REQ-020 The FSM SHALL have states IDLE and WAIT_MEM; EX_READY SHALL be 1 in IDLE and 0 in WAIT_MEM.
REQ-021 An instruction SHALL be accepted on a cycle with EX_VALID=1 and EX_READY=1.
REQ-022 A non-load accepted at edge N SHALL drive WE=EX_WEN&&(EX_RD!=0), A3=EX_RD and WB=EX_RESULT for the cycle after edge N, and increment INSTRET at that edge; the FSM stays in IDLE.
REQ-023 An accepted load SHALL latch rd, funct3 and address[1:0], clear the timeout counter and enter WAIT_MEM; BUSY=1 and BUSY_RD=latched rd in WAIT_MEM.
REQ-024 In WAIT_MEM with MEM_RVALID=1, the next cycle SHALL present extracted data with WE=(rd!=0), increment INSTRET and return to IDLE.
REQ-025 Extraction: 000 LB byte at addr[1:0]*8, sign-extended; 001 LH halfword at addr[1]*16, sign-extended; 010 LW full word; 100 LBU zero-extended; 101 LHU zero-extended.
REQ-026 funct3 of 011, 110 or 111, LH/LHU with addr[0]=1, or LW with addr[1:0]!=0 SHALL pulse LOAD_ERR with WE=0 and no INSTRET increment on response; the FSM returns to IDLE.
REQ-027 Each WAIT_MEM cycle without MEM_RVALID SHALL increment the timeout counter; on reaching MEM_TIMEOUT, the block SHALL pulse LOAD_ERR with WE=0, leave INSTRET unchanged and return to IDLE.
REQ-028 If MEM_RVALID=1 on the same cycle the timeout is reached, the response SHALL win.
REQ-029 MEM_RVALID in IDLE SHALL be ignored.
REQ-030 A3, WB, WE and LOAD_ERR SHALL be registered outputs; WE and LOAD_ERR SHALL never be 1 in the same cycle.
REQ-031 INSTRET SHALL wrap from 2^64-1 to 0; rd=0 instructions SHALL still retire.
REQ-032 Back-to-back non-loads SHALL sustain one retire per cycle.

Reset
REQ-033 While RST=0: FSM=IDLE, A3=0, WB=0, WE=0, LOAD_ERR=0, BUSY=0, BUSY_RD=0, INSTRET=0, timeout counter=0.
REQ-034 Reset during WAIT_MEM SHALL abort the load with no WE and no LOAD_ERR; a MEM_RVALID after reset release SHALL be ignored.

Verification
REQ-035 ALU op rd=5, result 0xDEADBEEF -> next cycle WE=1, A3=5, WB=0xDEADBEEF, INSTRET=1.
REQ-036 LB addr[1:0]=3, MEM_RDATA=0x80123456, response after 4 cycles -> BUSY=1 and BUSY_RD=rd for 4 cycles, then WB=0xFFFFFF80, WE=1.
REQ-037 LHU addr[1:0]=2, MEM_RDATA=0xBEEF1234 -> WB=0x0000BEEF; LH addr[1:0]=1 -> LOAD_ERR=1, WE=0, INSTRET unchanged.
REQ-038 MEM_TIMEOUT=4, load with no response -> LOAD_ERR pulse 4 cycles after entering WAIT_MEM, EX_READY=1 next cycle; a repeat run with MEM_RVALID on the 4th cycle -> WE=1 and no LOAD_ERR.
REQ-039 ALU op with rd=0 -> WE=0, INSTRET increments; preload INSTRET via 2^64-1 retires or force -> wraps to 0.
REQ-040 Assert RST=0 in WAIT_MEM, then MEM_RVALID=1 after release -> no WE, no LOAD_ERR, all outputs 0.
